bsg_lfsr_range_sampler: RTL

//  Downstream consumer of bsg_lfsr: turns raw 32-bit pseudo-random words into uniform values in
//  [0, limit) by rejection sampling, with bounded retry and a modulo-fold fallback.

---
 rtl/bsg_lfsr_range_pkg.sv | 21 ++
 rtl/bsg_lfsr_range_mask.sv | 26 ++
 rtl/bsg_lfsr_range_sampler.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/bsg_lfsr_range_pkg.sv
// Shared types and sizing helpers for the LFSR range sampler.
// The optional statistics port is controlled by BSG_LFSR_RANGE_SAMPLER_STATS_EN
// (see bsg_lfsr_range_sampler.sv).
package bsg_lfsr_range_pkg;

    // Two-state controller: draw words until one is usable, then present it.
    typedef enum logic {
        S_SAMPLE = 1'b0,
        S_HOLD   = 1'b1
    } bsg_lfsr_range_state_e;

    // Retry counter sizing for the default retry budget.
    localparam int unsigned default_max_retry_lp   = 4;
    localparam int unsigned default_retry_width_lp = $clog2(default_max_retry_lp + 1);

    // Retry counter width for an arbitrary retry budget.
    function automatic int unsigned retry_width(input int unsigned max_retry);
        return $clog2(max_retry + 1);
    endfunction

endpackage

// File: rtl/bsg_lfsr_range_mask.sv
// Combinational limit -> mask conversion for the range sampler.
// The mask covers every bit at or below the MSB of (limit-1), so masking a
// random word yields a value below twice the limit. A limit of 0 means the
// full 2^width_p range and maps to an all-ones mask.
module bsg_lfsr_range_mask #(
    parameter int width_p = 16
) (
    input  logic [width_p-1:0] limit_i,
    output logic [width_p-1:0] mask_o
);

    // Enough doubling shifts to smear the top set bit across the whole word.
    localparam int stages_lp = (width_p > 1) ? $clog2(width_p) : 1;

    logic [width_p-1:0] smear;

    // OR-shift smear of limit-1; limit of zero is special-cased to all ones.
    always_comb begin
        smear = limit_i - width_p'(1);
        for (int i = 0; i < stages_lp; i++) begin
            smear = smear | (smear >> (1 << i));
        end
        mask_o = (limit_i == '0) ? '1 : smear;
    end

endmodule

// File: rtl/bsg_lfsr_range_sampler.sv
// Rejection sampler that converts raw LFSR words into uniform values in
// [0, limit). Each sample cycle consumes one LFSR word. A word whose masked
// value falls outside the range is rejected; after max_retry_p tries the last
// candidate is folded into range by subtracting the limit.
//
// Handshakes:
//   lfsr_yumi_o : high in every sample cycle (out of reset); the LFSR advances
//                 on each high cycle whether the word is kept or not.
//   v_o / yumi_i: v_o stays high with data_o stable until the consumer raises
//                 yumi_i (only legal while v_o is high); the transfer happens
//                 at that clock edge.
//
// Optional feature: define BSG_LFSR_RANGE_SAMPLER_STATS_EN to add
// reject_cnt_o, a saturating count of rejected words (folded ones included).
module bsg_lfsr_range_sampler
    import bsg_lfsr_range_pkg::*;
#(
    parameter int lfsr_width_p = 32,
    parameter int width_p      = 16,
    parameter int max_retry_p  = 4
) (
    input  logic                    clk,
    input  logic                    reset_n_i,
    input  logic [lfsr_width_p-1:0] lfsr_i,
    output logic                    lfsr_yumi_o,
    input  logic                    limit_v_i,
    input  logic [width_p-1:0]      limit_i,
    output logic                    v_o,
    output logic [width_p-1:0]      data_o,
    input  logic                    yumi_i
`ifdef BSG_LFSR_RANGE_SAMPLER_STATS_EN
    ,
    output logic [31:0]             reject_cnt_o
`endif
);

    localparam int retry_width_lp = retry_width(max_retry_p);

    bsg_lfsr_range_state_e state_r, state_n;
    logic [width_p-1:0]        limit_r, limit_n;
    logic [retry_width_lp-1:0] retry_r, retry_n;
    logic [width_p-1:0]        data_r, data_n;
    logic                      v_r, v_n;

    logic [width_p-1:0] mask;
    logic [width_p-1:0] cand;
    logic               accept;
    logic               last_try;
    logic               reject_event;

    bsg_lfsr_range_mask #(
        .width_p (width_p)
    ) mask_inst (
        .limit_i (limit_r),
        .mask_o  (mask)
    );

    // Only the low width_p bits of the LFSR word are drawn from.
    generate
        if (width_p < lfsr_width_p) begin : g_unused_hi
            logic unused_lfsr_hi;
            assign unused_lfsr_hi = ^lfsr_i[lfsr_width_p-1:width_p];
        end
    endgenerate

    assign cand     = lfsr_i[width_p-1:0] & mask;
    assign accept   = (limit_r == '0) || (cand < limit_r);
    assign last_try = (retry_r == retry_width_lp'(max_retry_p - 1));

    assign lfsr_yumi_o = reset_n_i && (state_r == S_SAMPLE);
    assign v_o         = v_r;
    assign data_o      = data_r;

    // Next-state and datapath decisions for the sample/hold controller.
    always_comb begin
        state_n      = state_r;
        limit_n      = limit_r;
        retry_n      = retry_r;
        data_n       = data_r;
        v_n          = v_r;
        reject_event = 1'b0;

        if (limit_v_i) begin
            limit_n = limit_i;
        end

        case (state_r)
            S_SAMPLE: begin
                if (limit_v_i) begin
                    // Word drawn under the old limit is thrown away.
                    retry_n = '0;
                end else if (accept) begin
                    data_n  = cand;
                    v_n     = 1'b1;
                    retry_n = '0;
                    state_n = S_HOLD;
                end else if (!last_try) begin
                    reject_event = 1'b1;
                    retry_n      = retry_r + retry_width_lp'(1);
                end else begin
                    // Out of retries: fold the candidate (< 2*limit) into range.
                    reject_event = 1'b1;
                    data_n       = cand - limit_r;
                    v_n          = 1'b1;
                    retry_n      = '0;
                    state_n      = S_HOLD;
                end
            end
            S_HOLD: begin
                // Either the consumer took the value or a new limit voids it.
                if (yumi_i || limit_v_i) begin
                    v_n     = 1'b0;
                    retry_n = '0;
                    state_n = S_SAMPLE;
                end
            end
            default: begin
                state_n = S_SAMPLE;
                v_n     = 1'b0;
                retry_n = '0;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            state_r <= S_SAMPLE;
            limit_r <= '0;
            retry_r <= '0;
            data_r  <= '0;
            v_r     <= 1'b0;
        end else begin
            state_r <= state_n;
            limit_r <= limit_n;
            retry_r <= retry_n;
            data_r  <= data_n;
            v_r     <= v_n;
        end
    end

`ifdef BSG_LFSR_RANGE_SAMPLER_STATS_EN
    logic [31:0] reject_cnt_r;

    // Saturating count of rejected words.
    always_ff @(posedge clk) begin
        if (!reset_n_i) begin
            reject_cnt_r <= '0;
        end else if (reject_event && (reject_cnt_r != '1)) begin
            reject_cnt_r <= reject_cnt_r + 32'd1;
        end
    end

    assign reject_cnt_o = reject_cnt_r;
`else
    logic unused_reject_event;
    assign unused_reject_event = reject_event;
`endif

endmodule
